fetch_ctrl: RTL

//  Sequences instruction fetch for the front end: owns the PC, issues one word-fetch at a time to
//  the instruction memory port, and pushes each returned word with its address into the fetch op

---
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_ctrl_if
// Brief   : Bundles the memory port, fetch op queue port and the pause/redirect
//           controls of the instruction fetch controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface fetch_ctrl_if;
   logic        rdy_in;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        mem_gnt_in;
   logic        mem_valid_in;
   logic [31:0] mem_data_in;
   logic        inst_valid_out;
   logic [31:0] inst_out;
   logic [31:0] addr_out;
   logic        foq_full_in;
   logic        predict_fail_in;
   logic [31:0] redirect_pc_in;

   // Fetch controller side
   modport master (
      input  rdy_in, mem_gnt_in, mem_valid_in, mem_data_in,
             foq_full_in, predict_fail_in, redirect_pc_in,
      output mem_req_out, mem_addr_out, inst_valid_out, inst_out, addr_out
   );

   // Environment side: memory, queue and branch unit
   modport slave (
      output rdy_in, mem_gnt_in, mem_valid_in, mem_data_in,
             foq_full_in, predict_fail_in, redirect_pc_in,
      input  mem_req_out, mem_addr_out, inst_valid_out, inst_out, addr_out
   );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fetch_ctrl
// Brief   : Front-end fetch sequencer. Owns the PC, keeps at most one word
//           fetch outstanding, offers each returned word with its address to
//           the fetch op queue, and drops responses made stale by a redirect.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   fetch_ctrl_if.master bus
);

   // Reset PC is always word aligned regardless of the parameter value
   localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      r_st;
   logic [31:0] r_pc;
   logic        r_discard;
   logic [31:0] r_inst;
   logic [31:0] r_addr;

   state_t      w_st_nxt;
   logic [31:0] w_pc_nxt;
   logic        w_discard_nxt;
   logic [31:0] w_inst_nxt;
   logic [31:0] w_addr_nxt;
   logic [31:0] w_redirect_pc;

   assign w_redirect_pc = bus.redirect_pc_in & ~32'h3;

   // Registered state; reset wins over pause, pause is folded into next-state
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_st      <= ST_REQ;
         r_pc      <= c_reset_pc;
         r_discard <= 1'b0;
         r_inst    <= 32'h0;
         r_addr    <= 32'h0;
      end else begin
         r_st      <= w_st_nxt;
         r_pc      <= w_pc_nxt;
         r_discard <= w_discard_nxt;
         r_inst    <= w_inst_nxt;
         r_addr    <= w_addr_nxt;
      end
   end

   // Next-state: hold everything while paused; a mispredict overrides the
   // normal flow and marks any in-flight response for discard
   always_comb begin
      w_st_nxt      = r_st;
      w_pc_nxt      = r_pc;
      w_discard_nxt = r_discard;
      w_inst_nxt    = r_inst;
      w_addr_nxt    = r_addr;

      if (bus.rdy_in) begin
         if (bus.predict_fail_in) begin
            w_pc_nxt = w_redirect_pc;
            case (r_st)
               ST_REQ: begin
                  if (bus.mem_gnt_in) begin
                     w_st_nxt      = ST_WAIT;
                     w_discard_nxt = 1'b1;
                  end
               end
               ST_WAIT: begin
                  if (bus.mem_valid_in) begin
                     w_st_nxt      = ST_REQ;
                     w_discard_nxt = 1'b0;
                  end else begin
                     w_discard_nxt = 1'b1;
                  end
               end
               ST_HOLD: begin
                  w_st_nxt = ST_REQ;
               end
               default: begin
                  w_st_nxt = ST_REQ;
               end
            endcase
         end else begin
            case (r_st)
               ST_REQ: begin
                  if (bus.mem_gnt_in) begin
                     w_st_nxt = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (bus.mem_valid_in) begin
                     if (r_discard) begin
                        // Stale word; PC already points at the redirect target
                        w_discard_nxt = 1'b0;
                        w_st_nxt      = ST_REQ;
                     end else begin
                        w_inst_nxt = bus.mem_data_in;
                        w_addr_nxt = r_pc;
                        w_st_nxt   = ST_HOLD;
                     end
                  end
               end
               ST_HOLD: begin
                  if (!bus.foq_full_in) begin
                     w_pc_nxt = r_pc + 32'd4;
                     w_st_nxt = ST_REQ;
                  end
               end
               default: begin
                  w_st_nxt = ST_REQ;
               end
            endcase
         end
      end
   end

   // Outputs are qualified by rdy_in so a pause cannot issue or push anything
   assign bus.mem_req_out    = (r_st == ST_REQ) && bus.rdy_in;
   assign bus.mem_addr_out   = r_pc;
   assign bus.inst_valid_out = (r_st == ST_HOLD) && bus.rdy_in;
   assign bus.inst_out       = r_inst;
   assign bus.addr_out       = r_addr;

endmodule
`default_nettype wire
